// File: rtl/pauli_frame_tracker_pkg.sv
// ----------------------------------------------------------------------------
// pauli_frame_tracker_pkg
// Shared constants and types for the Pauli frame tracker and the 5-qubit
// correction LUT that feeds it.
//   N_QUBITS            : number of data qubits in the code block
//   AXIS_X/Y/Z/IDLE     : axis tags carried alongside each correction
//   frame_t             : one X bit and one Z bit per data qubit
//   axis_touches_x/z    : which frame halves a given axis tag flips
// ----------------------------------------------------------------------------
package pauli_frame_tracker_pkg;

  localparam int N_QUBITS = 5;

  localparam logic [1:0] AXIS_X    = 2'd0;
  localparam logic [1:0] AXIS_Y    = 2'd1;
  localparam logic [1:0] AXIS_Z    = 2'd2;
  localparam logic [1:0] AXIS_IDLE = 2'd3;

  typedef struct packed {
    logic [N_QUBITS-1:0] x;
    logic [N_QUBITS-1:0] z;
  } frame_t;

  // A Y correction is X and Z applied together, so it flips both halves.
  function automatic logic axis_touches_x(input logic [1:0] axis);
    return (axis == AXIS_X) || (axis == AXIS_Y);
  endfunction

  function automatic logic axis_touches_z(input logic [1:0] axis);
    return (axis == AXIS_Z) || (axis == AXIS_Y);
  endfunction

endpackage

// File: rtl/pauli_frame_tracker_frame_snapshot_reg.sv
// ----------------------------------------------------------------------------
// frame_snapshot_reg
// Single-entry valid/ready holding register for frame snapshots. A load that
// arrives while a snapshot is pending and not being accepted this cycle is
// dropped, and the sticky overrun flag is raised. A load that coincides with
// a completing transfer replaces the outgoing entry and keeps out_valid high.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   load_i     : snapshot event this cycle
//   frame_i    : frame to capture
//   cnt_i      : error count to capture
//   out_ready  : host accepts the held snapshot
//   out_valid  : snapshot held
//   frame_o    : held frame
//   cnt_o      : held error count
//   overrun    : sticky, a snapshot was dropped
// ----------------------------------------------------------------------------
module frame_snapshot_reg
  import pauli_frame_tracker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  frame_t           frame_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             out_ready,
  output logic             out_valid,
  output frame_t           frame_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             overrun
);

  logic             valid_q,   valid_d;
  frame_t           frame_q,   frame_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             overrun_q, overrun_d;

  logic blocked;

  always_comb begin
    // Pending and not drained this cycle: nowhere to put a new snapshot.
    blocked   = valid_q && !out_ready;
    valid_d   = valid_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    if (load_i && !blocked) begin
      valid_d = 1'b1;
      frame_d = frame_i;
      cnt_d   = cnt_i;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (load_i && blocked) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= 1'b0;
      frame_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign frame_o   = frame_q;
  assign cnt_o     = cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/pauli_frame_tracker.sv
// ----------------------------------------------------------------------------
// pauli_frame_tracker
// Folds LUT corrections into a live Pauli frame (X and Z bit per qubit),
// counts completed decode rounds (a round ends on a Z-axis beat) and every
// ROUNDS rounds hands a frame snapshot plus window error count to the host
// over valid/ready. Also checks the X,Y,Z,idle axis rotation of the input.
// Ports:
//   CLK, RST              : clock, synchronous active-high reset
//   in_valid              : correction/axis valid this cycle
//   correction[4:0]       : one-hot or zero mask, bit 4 = qubit 0
//   axis[1:0]             : 0=X 1=Y 2=Z 3=idle
//   frame_clr             : clear live frame, round, error count, expected axis
//   out_valid/out_ready   : snapshot handshake
//   x_frame, z_frame      : snapshot frame
//   err_count             : nonzero corrections in the window, saturating
//   overrun               : sticky, snapshot dropped while one was pending
//   seq_err               : sticky, axis tag broke the rotation
// ----------------------------------------------------------------------------
module pauli_frame_tracker
  import pauli_frame_tracker_pkg::*;
#(
  parameter int ROUNDS = 4,
  parameter int CNT_W  = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  input  logic [N_QUBITS-1:0] correction,
  input  logic [1:0]          axis,
  input  logic                frame_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_QUBITS-1:0] x_frame,
  output logic [N_QUBITS-1:0] z_frame,
  output logic [CNT_W-1:0]    err_count,
  output logic                overrun,
  output logic                seq_err
);

  localparam int RND_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [N_QUBITS-1:0] lx_q,       lx_d;
  logic [N_QUBITS-1:0] lz_q,       lz_d;
  logic [RND_W-1:0]    rnd_q,      rnd_d;
  logic [CNT_W-1:0]    ecnt_q,     ecnt_d;
  logic [1:0]          exp_axis_q, exp_axis_d;
  logic                seq_err_q,  seq_err_d;

  logic                beat;
  logic                snap;
  logic [N_QUBITS-1:0] lx_upd;
  logic [N_QUBITS-1:0] lz_upd;
  logic [CNT_W-1:0]    ecnt_upd;
  frame_t              snap_frame;

  always_comb begin
    // frame_clr wins over a same-cycle beat; the beat is simply lost.
    beat   = in_valid && !frame_clr;
    lx_upd = lx_q;
    lz_upd = lz_q;
    if (beat && axis_touches_x(axis)) lx_upd = lx_q ^ correction;
    if (beat && axis_touches_z(axis)) lz_upd = lz_q ^ correction;

    ecnt_upd = ecnt_q;
    if (beat && (correction != '0) && (axis != AXIS_IDLE)) begin
      ecnt_upd = sat_inc(ecnt_q);
    end

    snap = beat && (axis == AXIS_Z) && (rnd_q == RND_W'(ROUNDS - 1));

    // Snapshot carries this beat's contribution, so it takes the updated values.
    snap_frame.x = lx_upd;
    snap_frame.z = lz_upd;

    lx_d       = lx_upd;
    lz_d       = lz_upd;
    ecnt_d     = snap ? '0 : ecnt_upd;
    rnd_d      = rnd_q;
    exp_axis_d = exp_axis_q;
    seq_err_d  = seq_err_q;

    if (beat) begin
      if (axis != exp_axis_q) seq_err_d = 1'b1;
      // Always follow the incoming tag so a single slip reports once.
      exp_axis_d = axis + 2'd1;
      if (axis == AXIS_Z) begin
        rnd_d = snap ? '0 : rnd_q + RND_W'(1);
      end
    end

    if (frame_clr) begin
      lx_d       = '0;
      lz_d       = '0;
      rnd_d      = '0;
      ecnt_d     = '0;
      exp_axis_d = AXIS_X;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lx_q       <= '0;
      lz_q       <= '0;
      rnd_q      <= '0;
      ecnt_q     <= '0;
      exp_axis_q <= AXIS_X;
      seq_err_q  <= 1'b0;
    end else begin
      lx_q       <= lx_d;
      lz_q       <= lz_d;
      rnd_q      <= rnd_d;
      ecnt_q     <= ecnt_d;
      exp_axis_q <= exp_axis_d;
      seq_err_q  <= seq_err_d;
    end
  end

  frame_t snap_out;

  frame_snapshot_reg #(
    .CNT_W (CNT_W)
  ) u_snapshot (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (snap),
    .frame_i   (snap_frame),
    .cnt_i     (ecnt_upd),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .frame_o   (snap_out),
    .cnt_o     (err_count),
    .overrun   (overrun)
  );

  assign x_frame = snap_out.x;
  assign z_frame = snap_out.z;
  assign seq_err = seq_err_q;

endmodule
